branch_resolution_unit: RTL and testbench

- Resolves branch predictions in the ID stage: compares the IF-stage prediction (taken bit, predicted target) against the actual branch outcome and target.
- On a mismatch, issues a registered redirect PC and a flush of the wrong-path IF/ID instructions.
- Emits a one-cycle update pulse per resolved branch to drive the prediction table write port, and keeps saturating branch and mispredict counters.

---
 rtl/branch_resolution_unit.sv | 158 +++++++++++++++
 tb/tb_branch_resolution_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolution_unit.sv
// Branch resolution in ID. The prediction made at fetch travels with its
// instruction in a small tag register and is compared against the real
// outcome once the branch reaches ID. A mismatch produces a one-cycle
// registered redirect/flush. Every resolved branch produces a one-cycle
// predictor update strobe and bumps saturating performance counters.
module branch_resolution_unit #(
  parameter int         PC_W       = 64,
  parameter int         CNT_W      = 16,
  parameter logic [6:0] BRANCH_OPC = 7'b1100011
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             if_valid,
  input  logic [PC_W-1:0]  if_pc,
  input  logic             if_pred_taken,
  input  logic [PC_W-1:0]  if_pred_target,
  input  logic             stall,
  input  logic [31:0]      id_inst,
  input  logic             id_taken,
  input  logic [PC_W-1:0]  id_branch_target,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             flush_if,
  output logic             flush_id,
  output logic             upd_valid,
  output logic [PC_W-1:0]  upd_pc,
  output logic             upd_taken,
  output logic [PC_W-1:0]  upd_target,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  typedef enum logic [0:0] {IDLE, REDIRECT} state_t;

  state_t state_reg, state_next;

  // Prediction metadata that accompanies the instruction from IF into ID.
  logic            tag_valid_reg;
  logic [PC_W-1:0] tag_pc_reg;
  logic            tag_pred_taken_reg;
  logic [PC_W-1:0] tag_pred_target_reg;

  logic             redirect_valid_reg;
  logic [PC_W-1:0]  redirect_pc_reg;
  logic             flush_if_reg;
  logic             flush_id_reg;
  logic             upd_valid_reg;
  logic [PC_W-1:0]  upd_pc_reg;
  logic             upd_taken_reg;
  logic [PC_W-1:0]  upd_target_reg;
  logic [CNT_W-1:0] branch_count_reg;
  logic [CNT_W-1:0] mispredict_count_reg;

  logic            is_br;
  logic            resolve;
  logic            mispredict;
  logic [PC_W-1:0] correct_pc;
  logic [PC_W-1:0] pc_plus4;

  // Only the opcode field matters for classification.
  logic unused_inst_bits;
  assign unused_inst_bits = ^id_inst[31:7];

  // Classify the ID instruction and work out whether the prediction was wrong.
  always_comb begin
    is_br      = (id_inst[6:0] == BRANCH_OPC);
    resolve    = tag_valid_reg && !stall && (state_reg == IDLE);
    pc_plus4   = tag_pc_reg + PC_W'(4);
    mispredict = 1'b0;
    correct_pc = '0;
    if (is_br) begin
      if (id_taken) begin
        // Taken: wrong if predicted not-taken or predicted the wrong target.
        if (!tag_pred_taken_reg || (tag_pred_target_reg != id_branch_target)) begin
          mispredict = 1'b1;
          correct_pc = id_branch_target;
        end
      end else if (tag_pred_taken_reg) begin
        mispredict = 1'b1;
        correct_pc = pc_plus4;
      end
    end else if (tag_pred_taken_reg) begin
      // Predictor aliased a non-branch onto a taken entry.
      mispredict = 1'b1;
      correct_pc = pc_plus4;
    end
  end

  // Next-state logic: a redirect lasts exactly one cycle regardless of stall.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (resolve && mispredict) state_next = REDIRECT;
      REDIRECT: state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // State, tag, registered outputs and counters; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_reg            <= IDLE;
      tag_valid_reg        <= 1'b0;
      tag_pc_reg           <= '0;
      tag_pred_taken_reg   <= 1'b0;
      tag_pred_target_reg  <= '0;
      redirect_valid_reg   <= 1'b0;
      redirect_pc_reg      <= '0;
      flush_if_reg         <= 1'b0;
      flush_id_reg         <= 1'b0;
      upd_valid_reg        <= 1'b0;
      upd_pc_reg           <= '0;
      upd_taken_reg        <= 1'b0;
      upd_target_reg       <= '0;
      branch_count_reg     <= '0;
      mispredict_count_reg <= '0;
    end else begin
      state_reg <= state_next;

      // Wrong-path contents are discarded during a redirect; stall holds.
      if (state_reg == REDIRECT) begin
        tag_valid_reg <= 1'b0;
      end else if (!stall) begin
        tag_valid_reg       <= if_valid;
        tag_pc_reg          <= if_pc;
        tag_pred_taken_reg  <= if_pred_taken;
        tag_pred_target_reg <= if_pred_target;
      end

      redirect_valid_reg <= resolve && mispredict;
      flush_if_reg       <= resolve && mispredict;
      flush_id_reg       <= resolve && mispredict;
      redirect_pc_reg    <= (resolve && mispredict) ? correct_pc : '0;

      upd_valid_reg  <= resolve && is_br;
      upd_pc_reg     <= (resolve && is_br) ? tag_pc_reg : '0;
      upd_taken_reg  <= resolve && is_br && id_taken;
      upd_target_reg <= (resolve && is_br) ? id_branch_target : '0;

      if (resolve && is_br && (branch_count_reg != {CNT_W{1'b1}}))
        branch_count_reg <= branch_count_reg + CNT_W'(1);
      if (resolve && mispredict && (mispredict_count_reg != {CNT_W{1'b1}}))
        mispredict_count_reg <= mispredict_count_reg + CNT_W'(1);
    end
  end

  assign redirect_valid   = redirect_valid_reg;
  assign redirect_pc      = redirect_pc_reg;
  assign flush_if         = flush_if_reg;
  assign flush_id         = flush_id_reg;
  assign upd_valid        = upd_valid_reg;
  assign upd_pc           = upd_pc_reg;
  assign upd_taken        = upd_taken_reg;
  assign upd_target       = upd_target_reg;
  assign branch_count     = branch_count_reg;
  assign mispredict_count = mispredict_count_reg;

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Directed bench for branch_resolution_unit (narrow counters to reach saturation).
module tb_branch_resolution_unit;

  localparam int PC_W  = 64;
  localparam int CNT_W = 4;
  localparam logic [31:0] BR  = 32'h0020_8063;  // beq
  localparam logic [31:0] NOP = 32'h0000_0013;  // addi x0,x0,0

  logic             clk = 1'b0;
  logic             arst_n;
  logic             if_valid;
  logic [PC_W-1:0]  if_pc;
  logic             if_pred_taken;
  logic [PC_W-1:0]  if_pred_target;
  logic             stall;
  logic [31:0]      id_inst;
  logic             id_taken;
  logic [PC_W-1:0]  id_branch_target;
  logic             redirect_valid;
  logic [PC_W-1:0]  redirect_pc;
  logic             flush_if;
  logic             flush_id;
  logic             upd_valid;
  logic [PC_W-1:0]  upd_pc;
  logic             upd_taken;
  logic [PC_W-1:0]  upd_target;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;

  int tests = 0;
  int failed = 0;

  branch_resolution_unit #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .arst_n(arst_n),
    .if_valid(if_valid), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .if_pred_target(if_pred_target), .stall(stall),
    .id_inst(id_inst), .id_taken(id_taken), .id_branch_target(id_branch_target),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_if(flush_if), .flush_id(flush_id),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Put a fetched instruction into the tag while ID holds a harmless NOP.
  task automatic load_tag(input logic [63:0] pc, input logic pt, input logic [63:0] ptgt);
    if_valid = 1'b1; if_pc = pc; if_pred_taken = pt; if_pred_target = ptgt;
    id_inst = NOP; id_taken = 1'b0; id_branch_target = '0; stall = 1'b0;
    tick();
  endtask

  // Present the ID-side outcome for the tagged instruction; IF is a bubble.
  task automatic resolve(input logic [31:0] inst, input logic tk, input logic [63:0] tgt);
    if_valid = 1'b0; if_pc = '0; if_pred_taken = 1'b0; if_pred_target = '0;
    id_inst = inst; id_taken = tk; id_branch_target = tgt; stall = 1'b0;
    tick();
  endtask

  task automatic idle();
    if_valid = 1'b0; if_pred_taken = 1'b0; id_inst = NOP; id_taken = 1'b0; stall = 1'b0;
    tick();
  endtask

  task automatic show(input string what);
    $display("[TB] %s: rv=%0b rpc=%0h fl=%0b%0b upd=%0b upc=%0h ut=%0b utg=%0h bc=%0d mc=%0d",
             what, redirect_valid, redirect_pc, flush_if, flush_id, upd_valid, upd_pc,
             upd_taken, upd_target, branch_count, mispredict_count);
  endtask

  initial begin
    arst_n = 1'b0; if_valid = 1'b0; if_pc = '0; if_pred_taken = 1'b0; if_pred_target = '0;
    stall = 1'b0; id_inst = NOP; id_taken = 1'b0; id_branch_target = '0;
    tick(); tick();
    show("reset");
    chk("rst_rv", redirect_valid, 0); chk("rst_flush", {flush_if, flush_id}, 0);
    chk("rst_upd", upd_valid, 0); chk("rst_bc", branch_count, 0); chk("rst_mc", mispredict_count, 0);
    arst_n = 1'b1;
    idle();

    // Correct not-taken branch.
    load_tag(64'h100, 1'b0, 64'h0);
    resolve(BR, 1'b0, 64'h140);
    show("correct not-taken");
    chk("nt_upd", upd_valid, 1); chk("nt_upc", upd_pc, 64'h100); chk("nt_ut", upd_taken, 0);
    chk("nt_utg", upd_target, 64'h140); chk("nt_rv", redirect_valid, 0);
    chk("nt_bc", branch_count, 1); chk("nt_mc", mispredict_count, 0);

    // Taken but predicted not-taken (a).
    load_tag(64'h200, 1'b0, 64'h0);
    resolve(BR, 1'b1, 64'h180);
    show("case a");
    chk("a_rv", redirect_valid, 1); chk("a_fl", {flush_if, flush_id}, 2'b11);
    chk("a_rpc", redirect_pc, 64'h180); chk("a_upd", upd_valid, 1); chk("a_ut", upd_taken, 1);
    chk("a_bc", branch_count, 2); chk("a_mc", mispredict_count, 1);
    // REDIRECT cycle: a valid IF prediction is offered but must be discarded.
    if_valid = 1'b1; if_pc = 64'h500; if_pred_taken = 1'b1; if_pred_target = 64'h900;
    id_inst = BR; id_taken = 1'b1; id_branch_target = 64'h180;
    tick();
    show("after redirect");
    chk("a2_rv", redirect_valid, 0); chk("a2_fl", {flush_if, flush_id}, 0);
    chk("a2_rpc", redirect_pc, 0); chk("a2_upd", upd_valid, 0); chk("a2_bc", branch_count, 2);
    if_valid = 1'b0;
    tick();
    show("flushed tag ignored");
    chk("a3_upd", upd_valid, 0); chk("a3_rv", redirect_valid, 0); chk("a3_bc", branch_count, 2);

    // Wrong target (b).
    load_tag(64'h280, 1'b1, 64'h300);
    resolve(BR, 1'b1, 64'h340);
    show("case b");
    chk("b_rv", redirect_valid, 1); chk("b_rpc", redirect_pc, 64'h340);
    chk("b_bc", branch_count, 3); chk("b_mc", mispredict_count, 2);
    idle();

    // Correct taken with matching target.
    load_tag(64'h290, 1'b1, 64'h340);
    resolve(BR, 1'b1, 64'h340);
    show("correct taken");
    chk("t_rv", redirect_valid, 0); chk("t_upd", upd_valid, 1); chk("t_utg", upd_target, 64'h340);
    chk("t_bc", branch_count, 4); chk("t_mc", mispredict_count, 2);

    // Alias on a non-branch (d).
    load_tag(64'h400, 1'b1, 64'h480);
    resolve(NOP, 1'b0, 64'h0);
    show("case d");
    chk("d_rv", redirect_valid, 1); chk("d_rpc", redirect_pc, 64'h404);
    chk("d_upd", upd_valid, 0); chk("d_bc", branch_count, 4); chk("d_mc", mispredict_count, 3);
    idle();

    // Stall with a valid branch tag.
    load_tag(64'h600, 1'b0, 64'h0);
    if_valid = 1'b0; id_inst = BR; id_taken = 1'b0; id_branch_target = 64'h640; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      show("stalled");
      chk("st_upd", upd_valid, 0);
    end
    stall = 1'b0;
    tick();
    show("stall released");
    chk("st_rel_upd", upd_valid, 1); chk("st_rel_upc", upd_pc, 64'h600); chk("st_bc", branch_count, 5);
    idle();
    chk("st_once", upd_valid, 0);

    // Stall held through REDIRECT: pulse still one cycle.
    load_tag(64'h700, 1'b0, 64'h0);
    resolve(BR, 1'b1, 64'h780);
    chk("sr_rv", redirect_valid, 1);
    stall = 1'b1;
    tick();
    show("stall in redirect");
    chk("sr_rv2", redirect_valid, 0); chk("sr_fl2", {flush_if, flush_id}, 0);
    stall = 1'b0;
    idle();
    chk("sr_rv3", redirect_valid, 0); chk("sr_bc", branch_count, 6); chk("sr_mc", mispredict_count, 4);

    // PC wrap on not-taken redirect (c).
    load_tag(64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 64'h10);
    resolve(BR, 1'b0, 64'h10);
    show("case c wrap");
    chk("c_rv", redirect_valid, 1); chk("c_rpc", redirect_pc, 64'h0);
    chk("c_bc", branch_count, 7); chk("c_mc", mispredict_count, 5);
    idle();

    // Ten more correct branches -> 17 total, counter saturates at 15.
    for (int i = 0; i < 10; i++) begin
      load_tag(64'h1000 + 64'(i * 8), 1'b0, 64'h0);
      resolve(BR, 1'b0, 64'h2000);
    end
    show("saturation");
    chk("sat_bc", branch_count, 15); chk("sat_mc", mispredict_count, 5);

    // Reset in the redirect cycle; reset level alone does nothing.
    load_tag(64'h800, 1'b0, 64'h0);
    resolve(BR, 1'b1, 64'h880);
    chk("rr_rv", redirect_valid, 1); chk("rr_mc", mispredict_count, 6);
    arst_n = 1'b0;
    #2;
    show("reset low, no edge");
    chk("rr_hold_rv", redirect_valid, 1); chk("rr_hold_bc", branch_count, 15);
    idle();
    show("reset mid-redirect");
    chk("rr_rv0", redirect_valid, 0); chk("rr_fl0", {flush_if, flush_id}, 0);
    chk("rr_rpc0", redirect_pc, 0); chk("rr_upd0", upd_valid, 0);
    chk("rr_bc0", branch_count, 0); chk("rr_mc0", mispredict_count, 0);
    arst_n = 1'b1;
    idle();
    chk("rr_idle_rv", redirect_valid, 0);
    load_tag(64'h900, 1'b0, 64'h0);
    resolve(BR, 1'b0, 64'h940);
    show("after reset");
    chk("rr_upd", upd_valid, 1); chk("rr_rv", redirect_valid, 0); chk("rr_bc", branch_count, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
